// File: rtl/switch_sequencer_if.sv
// Bundle of the sequencer's control and status signals.
// master: side that drives enable/switch_i_c/count_in/green minutes and
//         observes interval/restart/lights/phase/error.
// slave : the sequencer itself.
interface switch_sequencer_if;
    logic        enable;
    logic        switch_i_c;
    logic [20:0] count_in;
    logic [15:0] green_a_min;
    logic [15:0] green_b_min;
    logic [15:0] interval;
    logic        restart;
    logic [2:0]  light_a;
    logic [2:0]  light_b;
    logic [2:0]  phase;
    logic        error;

    modport master (
        output enable, switch_i_c, count_in, green_a_min, green_b_min,
        input  interval, restart, light_a, light_b, phase, error
    );

    modport slave (
        input  enable, switch_i_c, count_in, green_a_min, green_b_min,
        output interval, restart, light_a, light_b, phase, error
    );
endinterface

// File: rtl/switch_sequencer.sv
// Two-road traffic light sequencer.
// Cycles A_GREEN -> A_YELLOW -> RED_AB -> B_GREEN -> B_YELLOW -> RED_BA.
// Green ends on a rising edge of switch_i_c; yellow and all-red are timed
// by a 4-bit phase timer. Entering a green state pulses restart and loads
// that road's green minutes into interval for the external counter.
// Ports:
//   clock  - sole clock, rising edge
//   reset  - synchronous active-high reset, priority over enable
//   bus    - switch_sequencer_if.slave (enable, switch_i_c, count_in,
//            green_a_min, green_b_min in; interval, restart, light_a,
//            light_b, phase, error out)
// Optional feature: define SWITCH_SEQ_WATCHDOG_EN to enable the green
// watchdog (count_in >= 60*interval forces yellow and sets sticky error).
module switch_sequencer #(
    parameter int unsigned YELLOW_SEC  = 4,
    parameter int unsigned ALL_RED_SEC = 1
) (
    input  logic               clock,
    input  logic               reset,
    switch_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        RED_AB   = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        RED_BA   = 3'd5
    } state_t;

    localparam logic [3:0] YELLOW_LAST  = 4'(YELLOW_SEC - 1);
    localparam logic [3:0] ALL_RED_LAST = 4'(ALL_RED_SEC - 1);

    state_t      state_q, state_d;
    logic [3:0]  timer_q, timer_d;
    logic        sw_q, sw_d;
    logic [15:0] interval_q, interval_d;
    logic        restart_q, restart_d;
    logic        sw_edge;
    logic        wd_hit;
    logic [15:0] green_a_val;
    logic [15:0] green_b_val;

`ifdef SWITCH_SEQ_WATCHDOG_EN
    logic        error_q, error_d;
    logic [21:0] wd_limit;
`endif

    // A zero-minute green would stall the counter, so it is promoted to 1.
    assign green_a_val = (bus.green_a_min == '0) ? 16'd1 : bus.green_a_min;
    assign green_b_val = (bus.green_b_min == '0) ? 16'd1 : bus.green_b_min;

    assign sw_edge = bus.switch_i_c & ~sw_q;

`ifdef SWITCH_SEQ_WATCHDOG_EN
    // 16-bit minutes times 60 fits exactly in 22 bits.
    assign wd_limit = {6'd0, interval_q} * 22'd60;
    assign wd_hit   = ({1'b0, bus.count_in} >= wd_limit) & ~sw_edge;
`else
    assign wd_hit   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sw_d       = sw_q;
        interval_d = interval_q;
        restart_d  = 1'b0;
`ifdef SWITCH_SEQ_WATCHDOG_EN
        error_d    = error_q;
`endif
        if (bus.enable) begin
            sw_d = bus.switch_i_c;
            case (state_q)
                A_GREEN, B_GREEN: begin
                    if (sw_edge | wd_hit) begin
                        state_d = (state_q == A_GREEN) ? A_YELLOW : B_YELLOW;
                        timer_d = '0;
`ifdef SWITCH_SEQ_WATCHDOG_EN
                        if (wd_hit) error_d = 1'b1;
`endif
                    end
                end
                A_YELLOW, B_YELLOW: begin
                    if (timer_q == YELLOW_LAST) begin
                        state_d = (state_q == A_YELLOW) ? RED_AB : RED_BA;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 4'd1;
                    end
                end
                RED_AB: begin
                    if (timer_q == ALL_RED_LAST) begin
                        state_d    = B_GREEN;
                        timer_d    = '0;
                        restart_d  = 1'b1;
                        interval_d = green_b_val;
                    end else begin
                        timer_d = timer_q + 4'd1;
                    end
                end
                RED_BA: begin
                    if (timer_q == ALL_RED_LAST) begin
                        state_d    = A_GREEN;
                        timer_d    = '0;
                        restart_d  = 1'b1;
                        interval_d = green_a_val;
                    end else begin
                        timer_d = timer_q + 4'd1;
                    end
                end
                default: begin
                    // Unused codes recover into A_GREEN as a normal green entry.
                    state_d    = A_GREEN;
                    timer_d    = '0;
                    restart_d  = 1'b1;
                    interval_d = green_a_val;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= A_GREEN;
            timer_q    <= '0;
            sw_q       <= 1'b0;
            interval_q <= green_a_val;
            restart_q  <= 1'b0;
`ifdef SWITCH_SEQ_WATCHDOG_EN
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sw_q       <= sw_d;
            interval_q <= interval_d;
            restart_q  <= restart_d;
`ifdef SWITCH_SEQ_WATCHDOG_EN
            error_q    <= error_d;
`endif
        end
    end

    always_comb begin
        bus.light_a = 3'b100;
        bus.light_b = 3'b100;
        case (state_q)
            A_GREEN:  begin bus.light_a = 3'b001; bus.light_b = 3'b100; end
            A_YELLOW: begin bus.light_a = 3'b010; bus.light_b = 3'b100; end
            B_GREEN:  begin bus.light_a = 3'b100; bus.light_b = 3'b001; end
            B_YELLOW: begin bus.light_a = 3'b100; bus.light_b = 3'b010; end
            default:  begin bus.light_a = 3'b100; bus.light_b = 3'b100; end
        endcase
    end

    assign bus.phase    = state_q;
    assign bus.interval = interval_q;
    assign bus.restart  = restart_q;
`ifdef SWITCH_SEQ_WATCHDOG_EN
    assign bus.error    = error_q;
`else
    assign bus.error    = 1'b0;
`endif

endmodule

// File: tb/tb_switch_sequencer.sv
module tb_switch_sequencer;

    localparam int YEL = 4;
    localparam int RED = 1;

    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    switch_sequencer_if bus ();

    switch_sequencer #(
        .YELLOW_SEC  (YEL),
        .ALL_RED_SEC (RED)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: phase index walks 0..5 in order; timed phases count
    // down a "cycles left" budget taken from a duration table.
    int m_phase, m_left, m_prev, m_interval, m_restart, m_error;

    function automatic int min_fix(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [5:0] lights_of(input int p);
        case (p)
            0: return {3'b001, 3'b100};
            1: return {3'b010, 3'b100};
            3: return {3'b100, 3'b001};
            4: return {3'b100, 3'b010};
            default: return {3'b100, 3'b100};
        endcase
    endfunction

    task automatic model_step();
        int edge_seen, wd;
        if (reset) begin
            m_phase = 0; m_left = 0; m_prev = 0; m_restart = 0; m_error = 0;
            m_interval = min_fix(int'(bus.green_a_min));
        end else if (!bus.enable) begin
            m_restart = 0;
        end else begin
            edge_seen = (bus.switch_i_c && !m_prev) ? 1 : 0;
            m_prev = bus.switch_i_c;
            m_restart = 0;
            if (m_phase == 0 || m_phase == 3) begin
                wd = 0;
`ifdef SWITCH_SEQ_WATCHDOG_EN
                if (int'(bus.count_in) >= 60 * m_interval && !edge_seen) wd = 1;
`endif
                if (wd) m_error = 1;
                if (edge_seen || wd) begin m_phase++; m_left = YEL; end
            end else if (m_phase == 1 || m_phase == 4) begin
                m_left--;
                if (m_left == 0) begin m_phase++; m_left = RED; end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = (m_phase + 1) % 6;
                    m_restart = 1;
                    m_interval = (m_phase == 3) ? min_fix(int'(bus.green_b_min))
                                                : min_fix(int'(bus.green_a_min));
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset(input logic [15:0] ga, input logic [15:0] gb);
        bus.green_a_min = ga;
        bus.green_b_min = gb;
        bus.switch_i_c  = 1'b0;
        bus.count_in    = '0;
        bus.enable      = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(16'd7, 16'd3);
        total_cnt++; if (bus.phase !== 3'd0) $display("FAIL reset_phase: got %0d expected 0", bus.phase); else pass_cnt++;
        total_cnt++; if (bus.light_a !== 3'b001) $display("FAIL reset_light_a: got %b expected 001", bus.light_a); else pass_cnt++;
        total_cnt++; if (bus.light_b !== 3'b100) $display("FAIL reset_light_b: got %b expected 100", bus.light_b); else pass_cnt++;
        total_cnt++; if (bus.restart !== 1'b0) $display("FAIL reset_restart: got %b expected 0", bus.restart); else pass_cnt++;
        total_cnt++; if (bus.interval !== 16'd7) $display("FAIL reset_interval: got %0d expected 7", bus.interval); else pass_cnt++;
        total_cnt++; if (bus.error !== 1'b0) $display("FAIL reset_error: got %b expected 0", bus.error); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            tick();
            total_cnt++;
            if ({bus.phase, bus.restart} !== 4'b0000)
                $display("FAIL idle_hold: got phase=%0d restart=%b expected phase=0 restart=0", bus.phase, bus.restart);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic_switch();
        apply_reset(16'd2, 16'd3);
        bus.switch_i_c = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            if (i == 6) bus.switch_i_c = 1'b0;
            tick();
            if (i <= 4) begin
                total_cnt++;
                if (bus.phase !== 3'd1 || bus.light_a !== 3'b010)
                    $display("FAIL basic_yellow[%0d]: got phase=%0d light_a=%b expected phase=1 light_a=010", i, bus.phase, bus.light_a);
                else pass_cnt++;
            end else if (i == 5) begin
                total_cnt++;
                if (bus.phase !== 3'd2 || bus.light_a !== 3'b100 || bus.light_b !== 3'b100)
                    $display("FAIL basic_red: got phase=%0d lights=%b/%b expected phase=2 lights=100/100", bus.phase, bus.light_a, bus.light_b);
                else pass_cnt++;
            end else if (i == 6) begin
                total_cnt++;
                if (bus.phase !== 3'd3 || bus.restart !== 1'b1 || bus.interval !== 16'd3 || bus.light_b !== 3'b001)
                    $display("FAIL basic_b_green: got phase=%0d restart=%b interval=%0d light_b=%b expected 3/1/3/001", bus.phase, bus.restart, bus.interval, bus.light_b);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (bus.phase !== 3'd3 || bus.restart !== 1'b0)
                    $display("FAIL basic_restart_pulse: got phase=%0d restart=%b expected 3/0", bus.phase, bus.restart);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_yellow_ignore();
        apply_reset(16'd2, 16'd6);
        for (int i = 1; i <= 6; i++) begin
            bus.switch_i_c = (i == 1 || i == 3) ? 1'b1 : 1'b0;
            tick();
            if (i == 5) begin
                total_cnt++;
                if (bus.phase !== 3'd2) $display("FAIL ignore_red: got %0d expected 2", bus.phase); else pass_cnt++;
            end else if (i == 6) begin
                total_cnt++;
                if (bus.phase !== 3'd3 || bus.interval !== 16'd6)
                    $display("FAIL ignore_b_green: got phase=%0d interval=%0d expected 3/6", bus.phase, bus.interval);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_enable_freeze();
        apply_reset(16'd2, 16'd4);
        bus.switch_i_c = 1'b1;
        tick();
        bus.switch_i_c = 1'b0;
        tick();
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.switch_i_c = i[0];
            tick();
            total_cnt++;
            if (bus.phase !== 3'd1 || bus.restart !== 1'b0)
                $display("FAIL freeze_hold[%0d]: got phase=%0d restart=%b expected 1/0", i, bus.phase, bus.restart);
            else pass_cnt++;
        end
        bus.enable = 1'b1;
        bus.switch_i_c = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total_cnt++;
            if (i <= 2 && bus.phase !== 3'd1)
                $display("FAIL freeze_yellow[%0d]: got %0d expected 1", i, bus.phase);
            else if (i == 3 && bus.phase !== 3'd2)
                $display("FAIL freeze_red: got %0d expected 2", bus.phase);
            else if (i == 4 && (bus.phase !== 3'd3 || bus.restart !== 1'b1))
                $display("FAIL freeze_b_green: got phase=%0d restart=%b expected 3/1", bus.phase, bus.restart);
            else pass_cnt++;
        end
    endtask

    task automatic test_zero_green();
        apply_reset(16'd0, 16'd5);
        total_cnt++;
        if (bus.interval !== 16'd1) $display("FAIL zero_reset_interval: got %0d expected 1", bus.interval); else pass_cnt++;
        bus.switch_i_c = 1'b1;
        tick();
        bus.switch_i_c = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++;
        if (bus.phase !== 3'd3 || bus.interval !== 16'd5)
            $display("FAIL zero_b_green: got phase=%0d interval=%0d expected 3/5", bus.phase, bus.interval);
        else pass_cnt++;
        bus.switch_i_c = 1'b1;
        tick();
        total_cnt++;
        if (bus.phase !== 3'd4 || bus.light_b !== 3'b010)
            $display("FAIL zero_b_yellow: got phase=%0d light_b=%b expected 4/010", bus.phase, bus.light_b);
        else pass_cnt++;
        bus.switch_i_c = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++;
        if (bus.phase !== 3'd0 || bus.restart !== 1'b1 || bus.interval !== 16'd1)
            $display("FAIL zero_a_green: got phase=%0d restart=%b interval=%0d expected 0/1/1", bus.phase, bus.restart, bus.interval);
        else pass_cnt++;
    endtask

    task automatic test_reset_midseq();
        apply_reset(16'd9, 16'd2);
        bus.switch_i_c = 1'b1;
        tick();
        tick();
        bus.switch_i_c = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (bus.phase !== 3'd0 || bus.restart !== 1'b0 || bus.interval !== 16'd9)
            $display("FAIL midseq_reset: got phase=%0d restart=%b interval=%0d expected 0/0/9", bus.phase, bus.restart, bus.interval);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            tick();
            total_cnt++;
            if (bus.phase !== 3'd0 || bus.restart !== 1'b0)
                $display("FAIL midseq_after[%0d]: got phase=%0d restart=%b expected 0/0", i, bus.phase, bus.restart);
            else pass_cnt++;
        end
    endtask

`ifdef SWITCH_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        apply_reset(16'd2, 16'd9);
        bus.count_in = 21'd119;
        tick();
        total_cnt++;
        if (bus.phase !== 3'd0 || bus.error !== 1'b0)
            $display("FAIL wd_below: got phase=%0d error=%b expected 0/0", bus.phase, bus.error);
        else pass_cnt++;
        bus.count_in = 21'd120;
        tick();
        total_cnt++;
        if (bus.phase !== 3'd1 || bus.error !== 1'b1)
            $display("FAIL wd_trip: got phase=%0d error=%b expected 1/1", bus.phase, bus.error);
        else pass_cnt++;
        bus.count_in = '0;
        for (int i = 0; i < 10; i++) tick();
        total_cnt++;
        if (bus.error !== 1'b1) $display("FAIL wd_sticky: got %b expected 1", bus.error); else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (bus.error !== 1'b0) $display("FAIL wd_clear: got %b expected 0", bus.error); else pass_cnt++;
    endtask
`endif

    task automatic test_random();
        logic [25:0] got, exp;
        logic [5:0]  lts;
        apply_reset(16'd3, 16'd2);
        for (int i = 0; i < 800; i++) begin
            reset          = ($urandom_range(0, 99) < 2);
            bus.enable     = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 2) == 0) bus.switch_i_c = ~bus.switch_i_c;
            if ($urandom_range(0, 19) == 0) bus.green_a_min = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) bus.green_b_min = 16'($urandom_range(0, 4));
            bus.count_in = 21'($urandom_range(0, 59));
            tick();
            lts = lights_of(m_phase);
            exp = {3'(m_phase), lts, 1'(m_restart), 16'(m_interval), 1'(m_error)};
            got = {bus.phase, bus.light_a, bus.light_b, bus.restart, bus.interval, bus.error};
            total_cnt++;
            if (got !== exp)
                $display("FAIL random[%0d]: got {phase,la,lb,restart,interval,error}=%h expected %h", i, got, exp);
            else pass_cnt++;
        end
        reset = 1'b0;
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.switch_i_c  = 1'b0;
        bus.count_in    = '0;
        bus.green_a_min = 16'd1;
        bus.green_b_min = 16'd1;
        m_phase = 0; m_left = 0; m_prev = 0; m_interval = 1; m_restart = 0; m_error = 0;
        test_reset();
        test_basic_switch();
        test_yellow_ignore();
        test_enable_freeze();
        test_zero_green();
        test_reset_midseq();
`ifdef SWITCH_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
